// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK levels and byte sizing.
// Used by both the target core and the bus master.
package i2c_pkg;

  localparam int         BYTE_W    = 8;
  localparam logic [3:0] BYTE_BITS = 4'd8;
  localparam logic       I2C_ACK   = 1'b0;
  localparam logic       I2C_NACK  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX_BYTE   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX_BYTE   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer for one asynchronous I2C line plus a history flop that yields
// single-cycle rise/fall pulses from the synchronized level.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2  // must be >= 2
) (
  input  logic clk,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;

  // Free-running on purpose: a core reset must not fabricate a bus edge
  // (e.g. a fake START) by forcing these flops away from the real line level.
  always_ff @(posedge clk) begin
    sync_reg <= {sync_reg[SYNC_STAGES-2:0], line_in};
    hist_reg <= sync_reg[SYNC_STAGES-1];
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = sync_reg[SYNC_STAGES-1] & ~hist_reg;
  assign fall  = ~sync_reg[SYNC_STAGES-1] & hist_reg;

endmodule

// File: rtl/i2c_slave_core.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// write bytes out on a valid/ready stream, read bytes in from a valid/pop stream.
module i2c_slave_core
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_pop,
  output logic              tx_underrun,
  output logic              start_det,
  output logic              stop_det,
  output logic              addressed,
  output logic              rw
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_cond, stop_cond;
  logic [BYTE_W-1:0] next_tx;

  i2c_state_t        state_reg;
  logic [3:0]        bit_cnt_reg;
  logic [BYTE_W-1:0] shift_reg;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .line_in(scl_in), .level(scl_s), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .line_in(sda_in), .level(sda_s), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_cond = scl_s & sda_fall;
  assign stop_cond  = scl_s & sda_rise;
  // An empty TX stream returns all-ones, which reads as a released bus.
  assign next_tx    = tx_valid ? tx_data : 8'hFF;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      sda_oe      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_pop      <= 1'b0;
      tx_underrun <= 1'b0;
      start_det   <= 1'b0;
      stop_det    <= 1'b0;
      addressed   <= 1'b0;
      rw          <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_pop      <= 1'b0;
      tx_underrun <= 1'b0;
      start_det   <= 1'b0;
      stop_det    <= 1'b0;

      if (start_cond) begin
        start_det   <= 1'b1;
        sda_oe      <= 1'b0;
        addressed   <= 1'b0;
        bit_cnt_reg <= '0;
        state_reg   <= ST_ADDR;
      end else if (stop_cond) begin
        stop_det    <= 1'b1;
        sda_oe      <= 1'b0;
        addressed   <= 1'b0;
        bit_cnt_reg <= '0;
        state_reg   <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: sda_oe <= 1'b0;

          ST_ADDR: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[BYTE_W-2:0], sda_s};
              // On the 8th bit shift_reg[6:0] already holds the complete address.
              if (bit_cnt_reg == BYTE_BITS - 4'd1) begin
                rw <= sda_s;
                if (shift_reg[6:0] == SLAVE_ADDR) begin
                  addressed   <= 1'b1;
                  bit_cnt_reg <= BYTE_BITS;
                  state_reg   <= ST_ADDR_ACK;
                end else begin
                  bit_cnt_reg <= '0;
                  state_reg   <= ST_WAIT_STOP;
                end
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (bit_cnt_reg == BYTE_BITS) begin
                sda_oe      <= 1'b1;
                bit_cnt_reg <= '0;
              end else if (rw) begin
                shift_reg   <= next_tx;
                sda_oe      <= ~next_tx[BYTE_W-1];
                tx_pop      <= tx_valid;
                tx_underrun <= ~tx_valid;
                state_reg   <= ST_TX_BYTE;
              end else begin
                sda_oe    <= 1'b0;
                state_reg <= ST_RX_BYTE;
              end
            end
          end

          ST_RX_BYTE: begin
            if (scl_rise && bit_cnt_reg != BYTE_BITS) begin
              shift_reg   <= {shift_reg[BYTE_W-2:0], sda_s};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (scl_fall && bit_cnt_reg == BYTE_BITS) begin
              bit_cnt_reg <= '0;
              if (rx_ready) begin
                rx_data   <= shift_reg;
                rx_valid  <= 1'b1;
                sda_oe    <= 1'b1;
                state_reg <= ST_RX_ACK;
              end else begin
                sda_oe    <= 1'b0;
                addressed <= 1'b0;
                state_reg <= ST_WAIT_STOP;
              end
            end
          end

          ST_RX_ACK: begin
            if (scl_fall) begin
              sda_oe    <= 1'b0;
              state_reg <= ST_RX_BYTE;
            end
          end

          ST_TX_BYTE: begin
            if (scl_rise && bit_cnt_reg != BYTE_BITS) begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_reg == BYTE_BITS) begin
                sda_oe      <= 1'b0;
                bit_cnt_reg <= '0;
                state_reg   <= ST_TX_ACK;
              end else begin
                shift_reg <= {shift_reg[BYTE_W-2:0], 1'b0};
                sda_oe    <= ~shift_reg[BYTE_W-2];
              end
            end
          end

          ST_TX_ACK: begin
            if (scl_rise && sda_s == I2C_NACK) begin
              addressed <= 1'b0;
              state_reg <= ST_WAIT_STOP;
            end else if (scl_fall) begin
              shift_reg   <= next_tx;
              sda_oe      <= ~next_tx[BYTE_W-1];
              tx_pop      <= tx_valid;
              tx_underrun <= ~tx_valid;
              state_reg   <= ST_TX_BYTE;
            end
          end

          ST_WAIT_STOP: sda_oe <= 1'b0;

          default: begin
            sda_oe    <= 1'b0;
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: bus-functional master at SCL = clk/20 on a
// wired-AND SDA with pull-up, table-driven write vectors plus directed sequences.
`timescale 1ns/1ps
module tb_i2c_slave_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       rx_ready = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic       sda_oe, rx_valid, tx_pop, tx_underrun;
  logic       start_det, stop_det, addressed, rw;
  logic [7:0] rx_data;
  logic       sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_core #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_pop(tx_pop), .tx_underrun(tx_underrun),
    .start_det(start_det), .stop_det(stop_det), .addressed(addressed), .rw(rw)
  );

  int         n_rx = 0, n_pop = 0, n_under = 0, n_start = 0, n_stop = 0, n_oe = 0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        n_rx <= n_rx + 1;
        rx_q.push_back(rx_data);
      end
      if (tx_pop)      n_pop   <= n_pop + 1;
      if (tx_underrun) n_under <= n_under + 1;
      if (start_det)   n_start <= n_start + 1;
      if (stop_det)    n_stop  <= n_stop + 1;
      if (sda_oe)      n_oe    <= n_oe + 1;
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: cycle budget of 100000 exhausted");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    sda_m = b;
    wait_clk(5);
    scl_m = 1'b1;
    wait_clk(5);
    r = sda_bus;
    wait_clk(5);
    scl_m = 1'b0;
    wait_clk(5);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_clk(5);
    scl_m = 1'b1;
    wait_clk(5);
    sda_m = 1'b0;
    wait_clk(5);
    scl_m = 1'b0;
    wait_clk(5);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_clk(5);
    scl_m = 1'b1;
    wait_clk(5);
    sda_m = 1'b1;
    wait_clk(5);
  endtask

  // ack = 1 when the target pulled SDA low in the ninth slot.
  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
    bus_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
    end
    bus_bit(nack, r);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ready;
    logic       exp_ack;
  } wr_vec_t;

  initial begin
    wr_vec_t    vecs[5];
    logic       ack;
    logic       r;
    logic [7:0] d;
    logic [7:0] exp_rx;
    int         s_rx, s_pop, s_under, s_start, s_stop, s_oe;

    vecs[0] = '{data: 8'h3C, ready: 1'b1, exp_ack: 1'b1};
    vecs[1] = '{data: 8'hA5, ready: 1'b1, exp_ack: 1'b1};
    vecs[2] = '{data: 8'h00, ready: 1'b1, exp_ack: 1'b1};
    vecs[3] = '{data: 8'hFF, ready: 1'b1, exp_ack: 1'b1};
    vecs[4] = '{data: 8'h77, ready: 1'b0, exp_ack: 1'b0};

    wait_clk(10);
    rst = 1'b0;
    wait_clk(3);
    chk("reset_sda_oe", sda_oe, 1'b0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_addressed", addressed, 1'b0);
    chk("reset_rw", rw, 1'b0);
    chk("reset_pulses", {rx_valid, tx_pop, tx_underrun, start_det, stop_det}, 5'b0);

    // Table: single-byte writes with varying data and backpressure.
    exp_rx = 8'h00;
    for (int v = 0; v < 5; v++) begin
      rx_ready = vecs[v].ready;
      s_rx = n_rx;
      bus_start();
      write_byte(8'hA0, ack);
      chk("tbl_addr_ack", ack, 1'b1);
      write_byte(vecs[v].data, ack);
      chk("tbl_data_ack", ack, vecs[v].exp_ack);
      bus_stop();
      if (vecs[v].ready) exp_rx = vecs[v].data;
      chk("tbl_rx_count", n_rx - s_rx, {31'd0, vecs[v].ready});
      chk("tbl_rx_data", rx_data, exp_rx);
      chk("tbl_addressed_after_stop", addressed, 1'b0);
      $display("vector %0d: data=0x%02h ready=%0b ack=%0b rx_data=0x%02h", v, vecs[v].data, vecs[v].ready, ack, rx_data);
    end
    rx_ready = 1'b1;

    // Two-byte write.
    s_rx = n_rx; s_start = n_start; s_stop = n_stop;
    bus_start();
    write_byte(8'hA0, ack);
    chk("wr_addr_ack", ack, 1'b1);
    chk("wr_addressed", addressed, 1'b1);
    chk("wr_rw", rw, 1'b0);
    write_byte(8'h3C, ack);
    chk("wr_ack1", ack, 1'b1);
    write_byte(8'h5A, ack);
    chk("wr_ack2", ack, 1'b1);
    bus_stop();
    chk("wr_rx_count", n_rx - s_rx, 2);
    chk("wr_rx0", rx_q[s_rx], 8'h3C);
    chk("wr_rx1", rx_q[s_rx+1], 8'h5A);
    chk("wr_start_count", n_start - s_start, 1);
    chk("wr_stop_count", n_stop - s_stop, 1);
    $display("write: rx=%0d start=%0d stop=%0d", n_rx - s_rx, n_start - s_start, n_stop - s_stop);

    // Read: one real byte then an underrun.
    tx_data = 8'h96; tx_valid = 1'b1;
    s_pop = n_pop; s_under = n_under;
    bus_start();
    write_byte(8'hA1, ack);
    tx_valid = 1'b0;
    chk("rd_addr_ack", ack, 1'b1);
    chk("rd_rw", rw, 1'b1);
    read_byte(1'b0, d);
    chk("rd_byte1", d, 8'h96);
    read_byte(1'b1, d);
    chk("rd_byte2_underrun", d, 8'hFF);
    chk("rd_sda_released", sda_oe, 1'b0);
    chk("rd_addressed_after_nack", addressed, 1'b0);
    bus_stop();
    chk("rd_pop_count", n_pop - s_pop, 1);
    chk("rd_underrun_count", n_under - s_under, 1);
    $display("read: pop=%0d underrun=%0d", n_pop - s_pop, n_under - s_under);

    // Address mismatch.
    s_rx = n_rx; s_pop = n_pop; s_oe = n_oe;
    bus_start();
    write_byte(8'h42, ack);
    chk("mis_ack", ack, 1'b0);
    chk("mis_addressed", addressed, 1'b0);
    bus_stop();
    chk("mis_oe_cycles", n_oe - s_oe, 0);
    chk("mis_rx_count", n_rx - s_rx, 0);
    chk("mis_pop_count", n_pop - s_pop, 0);
    $display("mismatch: ack=%0b oe_cycles=%0d", ack, n_oe - s_oe);

    // Repeated START switching write -> read.
    tx_data = 8'hC3; tx_valid = 1'b1;
    s_start = n_start;
    bus_start();
    write_byte(8'hA0, ack);
    chk("rs_addr1_ack", ack, 1'b1);
    chk("rs_rw_write", rw, 1'b0);
    write_byte(8'h11, ack);
    chk("rs_data_ack", ack, 1'b1);
    bus_start();
    write_byte(8'hA1, ack);
    tx_valid = 1'b0;
    chk("rs_addr2_ack", ack, 1'b1);
    chk("rs_rw_read", rw, 1'b1);
    read_byte(1'b1, d);
    chk("rs_read_data", d, 8'hC3);
    bus_stop();
    chk("rs_rx_data", rx_data, 8'h11);
    chk("rs_start_count", n_start - s_start, 2);
    $display("repeated start: rx_data=0x%02h read=0x%02h starts=%0d", rx_data, d, n_start - s_start);

    // Backpressure: data NACKed, then a fresh START is still answered.
    rx_ready = 1'b0;
    s_rx = n_rx;
    bus_start();
    write_byte(8'hA0, ack);
    chk("bp_addr_ack", ack, 1'b1);
    write_byte(8'h77, ack);
    chk("bp_data_nack", ack, 1'b0);
    chk("bp_addressed", addressed, 1'b0);
    chk("bp_rx_count", n_rx - s_rx, 0);
    rx_ready = 1'b1;
    bus_start();
    write_byte(8'hA0, ack);
    chk("bp_readdress_ack", ack, 1'b1);
    bus_stop();
    $display("backpressure: readdress ack=%0b", ack);

    // Reset during the 4th bit of a read of 0x00 (target holds SDA low).
    tx_data = 8'h00; tx_valid = 1'b1;
    bus_start();
    write_byte(8'hA1, ack);
    tx_valid = 1'b0;
    chk("rr_addr_ack", ack, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus_bit(1'b1, r);
      chk("rr_bit", r, 1'b0);
    end
    sda_m = 1'b1;
    wait_clk(5);
    scl_m = 1'b1;
    wait_clk(2);
    chk("rr_oe_before_reset", sda_oe, 1'b1);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    chk("rr_oe_after_reset", sda_oe, 1'b0);
    chk("rr_addressed_after_reset", addressed, 1'b0);
    wait_clk(3);
    scl_m = 1'b0;
    wait_clk(5);
    for (int i = 0; i < 5; i++) bus_bit(1'b1, r);
    bus_stop();
    bus_start();
    write_byte(8'hA0, ack);
    chk("rr_post_addr_ack", ack, 1'b1);
    write_byte(8'h12, ack);
    chk("rr_post_data_ack", ack, 1'b1);
    bus_stop();
    chk("rr_post_rx_data", rx_data, 8'h12);
    $display("reset mid-read: post rx_data=0x%02h", rx_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
